// File: rtl/pci_bus_arbiter_if.sv
// Request/grant and shared-bus monitor bundle between the PCI arbiter and its masters.
// The master modport is the arbiter side, and the slave modport is the device/bus side.
interface pci_bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2
);
  logic [N_MASTERS-1:0] REQ;
  logic                 FRAME;
  logic                 IRDY;
  logic [N_MASTERS-1:0] GNT;
  logic [ID_W-1:0]      GNT_ID;
  logic                 BUS_IDLE;

  modport master (
    input  REQ,
    input  FRAME,
    input  IRDY,
    output GNT,
    output GNT_ID,
    output BUS_IDLE
  );

  modport slave (
    output REQ,
    output FRAME,
    output IRDY,
    input  GNT,
    input  GNT_ID,
    input  BUS_IDLE
  );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with active-low REQ/GNT. Ownership moves only when FRAME and IRDY show an idle bus.
// Defining PCI_ARB_PARK_EN parks the idle bus on master 0.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int ID_W        = 2,
  parameter int GNT_TIMEOUT = 16
) (
  input logic               CLK,
  input logic               RST,
  pci_bus_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ONE      = N_MASTERS'(1);

`ifdef PCI_ARB_PARK_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_GAP,
    ST_PARK
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_GAP
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic                 bus_idle_q;

  logic                 bus_idle;
  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      cand;
  logic [N_MASTERS-1:0] owner_mask;
  logic                 others_req;
  logic                 owner_req;

  assign bus_idle   = bus.FRAME & bus.IRDY;
  assign owner_mask = ONE << owner_q;
  assign others_req = |(~bus.REQ & ~owner_mask);
  assign owner_req  = ~bus.REQ[owner_q];

  // Search for the first low REQ, starting at the master after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_MASTERS);
      if (!win_found && !bus.REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;

    unique case (state_q)
      // The GAP cycle is the turnaround. Its exit arbitrates directly, so exactly one all-high cycle separates owners.
      ST_IDLE, ST_GAP: begin
        gnt_d = '1;
        if (win_found) begin
          state_d  = ST_GRANT;
          gnt_d    = ~(ONE << win_idx);
          gnt_id_d = win_idx;
          owner_d  = win_idx;
          last_d   = win_idx;
          cnt_d    = '0;
        end else begin
`ifdef PCI_ARB_PARK_EN
          state_d  = ST_PARK;
          gnt_d    = ~ONE;
          gnt_id_d = '0;
`else
          state_d  = ST_IDLE;
`endif
        end
      end

      ST_GRANT: begin
        if (!bus_idle) begin
          state_d = ST_BUSY;
        end else if (!owner_req || (cnt_q == CNT_LAST)) begin
          // A withdrawn request or a timeout revoke both end this master's turn.
          state_d = ST_GAP;
          gnt_d   = '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BUSY: begin
        if (bus_idle) begin
          if (owner_req && !others_req) begin
            state_d = ST_GRANT;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            gnt_d   = '1;
          end
        end
      end

`ifdef PCI_ARB_PARK_EN
      // Parking never updates last, so the round-robin order is unaffected.
      ST_PARK: begin
        if (!bus_idle) begin
          state_d = ST_BUSY;
          owner_d = '0;
        end else if (!bus.REQ[0]) begin
          state_d  = ST_GRANT;
          owner_d  = '0;
          last_d   = '0;
          gnt_id_d = '0;
          cnt_d    = '0;
        end else if (win_found) begin
          state_d = ST_GAP;
          gnt_d   = '1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= ID_W'(N_MASTERS - 1);
      owner_q    <= '0;
      gnt_q      <= '1;
      gnt_id_q   <= '0;
      bus_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      bus_idle_q <= bus_idle;
    end
  end

  assign bus.GNT      = gnt_q;
  assign bus.GNT_ID   = gnt_id_q;
  assign bus.BUS_IDLE = bus_idle_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench for pci_bus_arbiter. It pushes the expected GNT, GNT_ID and BUS_IDLE for each driven cycle.
// It pops and compares those values at the following negedge. Build with PCI_ARB_PARK_EN to run the parking variant.
module tb_pci_bus_arbiter;
  localparam int N_MASTERS   = 4;
  localparam int ID_W        = 2;
  localparam int GNT_TIMEOUT = 16;

`ifdef PCI_ARB_PARK_EN
  localparam logic [3:0] REST_GNT = 4'b1110;
  localparam bit         PARK     = 1'b1;
`else
  localparam logic [3:0] REST_GNT = 4'b1111;
  localparam bit         PARK     = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       bidle;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  pci_bus_arbiter_if #(.N_MASTERS(N_MASTERS), .ID_W(ID_W)) bus ();

  pci_bus_arbiter #(
    .N_MASTERS  (N_MASTERS),
    .ID_W       (ID_W),
    .GNT_TIMEOUT(GNT_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of bus inputs at a negedge. Compare the registered response at the next negedge.
  task automatic cycle(input string tag, input logic [3:0] req, input logic frame, input logic irdy,
                       input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    exp_t e;
    bus.REQ   = req;
    bus.FRAME = frame;
    bus.IRDY  = irdy;
    e.tag   = tag;
    e.gnt   = exp_gnt;
    e.id    = exp_id;
    e.bidle = frame & irdy;
    sb_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    e = sb_q.pop_front();
    check({e.tag, ".gnt"},   8'(bus.GNT),      8'(e.gnt));
    check({e.tag, ".id"},    8'(bus.GNT_ID),   8'(e.id));
    check({e.tag, ".bidle"}, 8'(bus.BUS_IDLE), 8'(e.bidle));
  endtask

  // Grant a lone non-zero requester. When the bus is parked, a turnaround cycle comes first.
  task automatic start_grant(input string tag, input logic [3:0] req, input logic [1:0] id);
`ifdef PCI_ARB_PARK_EN
    cycle({tag, "_unpark"}, req, 1'b1, 1'b1, 4'b1111, 2'd0);
`endif
    cycle(tag, req, 1'b1, 1'b1, req, id);
  endtask

  // The owner drops REQ on an idle bus. Expect one GAP cycle, then the rest state.
  task automatic release_bus(input string tag, input logic [1:0] last_id);
    cycle({tag, "_gap"},  4'b1111, 1'b1, 1'b1, 4'b1111, last_id);
    cycle({tag, "_rest"}, 4'b1111, 1'b1, 1'b1, REST_GNT, PARK ? 2'd0 : last_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST       = 1'b0;
    bus.REQ   = 4'b0000;
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst.gnt",   8'(bus.GNT),      8'h0F);
    check("rst.id",    8'(bus.GNT_ID),   8'h00);
    check("rst.bidle", 8'(bus.BUS_IDLE), 8'h01);
    bus.FRAME = 1'b0;
    @(negedge CLK);
    check("rst_frame.bidle", 8'(bus.BUS_IDLE), 8'h01);
    check("rst_frame.gnt",   8'(bus.GNT),      8'h0F);
    RST = 1'b1;
    cycle("rst_rel", 4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0);

    // Round-robin with all masters requesting. Each owner runs a three-cycle FRAME.
    for (int i = 0; i < 4; i++) begin
      repeat (3) cycle("rr_frame", 4'b0000, 1'b0, 1'b0, ~(4'b0001 << i), 2'(i));
      cycle("rr_gap",  4'b0000, 1'b1, 1'b1, 4'b1111, 2'(i));
      cycle("rr_next", 4'b0000, 1'b1, 1'b1, ~(4'b0001 << ((i + 1) % 4)), 2'((i + 1) % 4));
    end
    release_bus("rr", 2'd0);

    // Back-to-back transfers by a lone requester. The grant is held across the idle cycle between them.
    start_grant("b2b_grant", 4'b1011, 2'd2);
    cycle("b2b_t1_addr", 4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2);
    cycle("b2b_t1_last", 4'b1011, 1'b1, 1'b0, 4'b1011, 2'd2);
    cycle("b2b_idle",    4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2);
    cycle("b2b_t2_addr", 4'b1011, 1'b0, 1'b1, 4'b1011, 2'd2);
    cycle("b2b_t2_data", 4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2);
    cycle("b2b_t2_end",  4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2);
    release_bus("b2b", 2'd2);

    // Timeout: the grant lasts 16 cycles without FRAME, then one GAP cycle, then a re-grant.
    start_grant("to_grant", 4'b1101, 2'd1);
    repeat (GNT_TIMEOUT - 1) cycle("to_hold", 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1);
    cycle("to_revoke",  4'b1101, 1'b1, 1'b1, 4'b1111, 2'd1);
    cycle("to_regrant", 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1);
    release_bus("to", 2'd1);

    // Withdraw: REQ[3] is released before FRAME.
    start_grant("wd_grant", 4'b0111, 2'd3);
    release_bus("wd", 2'd3);

    // An asynchronous reset during a transaction drops GNT without a clock edge.
    start_grant("mr_grant", 4'b1101, 2'd1);
    cycle("mr_busy", 4'b1101, 1'b0, 1'b0, 4'b1101, 2'd1);
    #2 RST = 1'b0;
    #1;
    check("mr_async.gnt",   8'(bus.GNT),      8'h0F);
    check("mr_async.id",    8'(bus.GNT_ID),   8'h00);
    check("mr_async.bidle", 8'(bus.BUS_IDLE), 8'h01);
    @(negedge CLK);
    check("mr_hold.gnt",   8'(bus.GNT),      8'h0F);
    check("mr_hold.bidle", 8'(bus.BUS_IDLE), 8'h01);
    RST = 1'b1;
    cycle("mr_rel", 4'b1111, 1'b1, 1'b1, REST_GNT, 2'd0);

    // Bus activity with no request. When parked, master 0 owns the bus until it goes idle.
    cycle("pk_frame", 4'b1111, 1'b0, 1'b0, REST_GNT, 2'd0);
    cycle("pk_end",   4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0);
    cycle("pk_rest",  4'b1111, 1'b1, 1'b1, REST_GNT, 2'd0);

    // Master 0 requests. Whether the bus is idle or parked, the grant comes without a gap.
    cycle("m0_grant", 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0);
    release_bus("m0", 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
